// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - opcodes, control state enum and mux select encodings
// Shared by the multicycle main FSM, the datapath and the ALU decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALRPC   = 4'd12,
    UPPER    = 4'd13,
    ILLEGAL  = 4'd14
  } ctrlState_e;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_PC        = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // R-type has no immediate; it falls through to the I encoding.
  function automatic logic [2:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_STORE:         immSrcFor = IMM_S;
      OP_BRANCH:        immSrcFor = IMM_B;
      OP_JAL:           immSrcFor = IMM_J;
      OP_LUI, OP_AUIPC: immSrcFor = IMM_U;
      default:          immSrcFor = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - Moore control FSM for the multicycle RV32I datapath
// Handshake states (FETCH, MEMREAD, MEMWRITE) stall until memory signals ready.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_UPPER  = 1'b1,
  parameter bit ENABLE_JALR   = 1'b1,
  parameter bit TRAP_ILLEGAL  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal
);

  ctrlState_e state, stateNext, illegalNext;
  logic       ready;
  logic       pcUpdate;
  logic       branch;

  assign ready       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign illegalNext = TRAP_ILLEGAL ? ILLEGAL : FETCH;
  assign ImmSrc      = immSrcFor(op);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    mem_req   = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    RegWrite  = 1'b0;
    illegal   = 1'b0;

    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = ready;
        pcUpdate  = ready;
        if (ready) stateNext = DECODE;
      end
      DECODE: begin
        // Branch target OldPC+imm is parked in ALUOut for BEQ.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: stateNext = MEMADR;
          OP_RTYPE:          stateNext = EXECR;
          OP_ITYPE:          stateNext = EXECI;
          OP_BRANCH:         stateNext = BEQ;
          OP_JAL:            stateNext = JAL;
          OP_JALR:           stateNext = ENABLE_JALR ? JALR : illegalNext;
          OP_LUI, OP_AUIPC:  stateNext = ENABLE_UPPER ? UPPER : illegalNext;
          default:           stateNext = illegalNext;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        stateNext = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (ready) stateNext = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        stateNext = FETCH;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = ready;
        if (ready) stateNext = FETCH;
      end
      EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        stateNext = FETCH;
      end
      BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        branch    = 1'b1;
        stateNext = FETCH;
      end
      JAL: begin
        // PC takes the DECODE target while OldPC+4 heads to ALUOut for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pcUpdate  = 1'b1;
        stateNext = ALUWB;
      end
      JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_PC;
        RegWrite  = 1'b1;
        stateNext = JALRPC;
      end
      JALRPC: begin
        pcUpdate  = 1'b1;
        stateNext = FETCH;
      end
      UPPER: begin
        ALUSrcA   = op[5] ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB   = SRCB_IMM;
        stateNext = ALUWB;
      end
      ILLEGAL: begin
        illegal   = 1'b1;
        stateNext = ILLEGAL;
      end
      default: stateNext = FETCH;
    endcase

    PCWrite = pcUpdate | (branch & zero);
  end

endmodule
